// File: rtl/uart_cmd_receiver.sv
// UART (8N1, LSB first) receiver and 5-byte command frame parser for the IAGC host link.
// Frames are HEADER, CMD, DATA_LO, DATA_HI, CHK with CHK = CMD ^ DATA_LO ^ DATA_HI.
module uart_cmd_receiver #(
   parameter int                        UART_CLK_FREQ  = 100_000_000,
   parameter int                        UART_BAUDRATE  = 9_200,
   parameter int                        UART_DATA_SIZE = 8,
   parameter int                        PAYLOAD_SIZE   = 16,
   parameter logic [UART_DATA_SIZE-1:0] HEADER_BYTE    = 8'hA5,
   parameter int                        TIMEOUT_TICKS  = 60_000_000
) (
   input  logic                      i_clock,
   input  logic                      i_rst_n,
   input  logic                      i_rxBit,
   output logic [UART_DATA_SIZE-1:0] o_cmd,
   output logic [PAYLOAD_SIZE-1:0]   o_payload,
   output logic                      o_cmdValid,
   output logic                      o_checksumError,
   output logic                      o_frameError,
   output logic                      o_timeout
);

   localparam int CLKS_PER_BIT = UART_CLK_FREQ / UART_BAUDRATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(UART_DATA_SIZE);
   localparam int TMR_W        = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_SIZE - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_state_t;
   typedef enum logic [2:0] {WAIT_HEADER, GET_CMD, GET_LO, GET_HI, GET_CHK} fr_state_t;

   function automatic logic [UART_DATA_SIZE-1:0] frame_chk(
      input logic [UART_DATA_SIZE-1:0] cmd,
      input logic [UART_DATA_SIZE-1:0] lo,
      input logic [UART_DATA_SIZE-1:0] hi
   );
      return cmd ^ lo ^ hi;
   endfunction

   logic rx_sync_p0, rx_sync_p1, rx_prev_p2;
   logic rx_fall;

   rx_state_t                 rx_state, rx_state_nxt;
   logic [CNT_W-1:0]          clk_cnt;
   logic [BIT_W-1:0]          bit_cnt;
   logic [UART_DATA_SIZE-1:0] rx_shift;
   logic                      bit_tick, byte_set, ferr_set, byte_stb;

   fr_state_t                 fr_state, fr_state_nxt;
   logic [TMR_W-1:0]          tmr;
   logic [UART_DATA_SIZE-1:0] cmd_b, lo_b, hi_b;
   logic                      cmd_vld_set, chk_err_set, tmo_set;

   // Stage p0/p1: metastability synchronizer; p2: previous value for edge detect
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
         rx_prev_p2 <= 1'b1;
      end else begin
         rx_sync_p0 <= i_rxBit;
         rx_sync_p1 <= rx_sync_p0;
         rx_prev_p2 <= rx_sync_p1;
      end
   end

   assign rx_fall = rx_prev_p2 & ~rx_sync_p1;

   // Bit-level receiver
   always_comb begin
      rx_state_nxt = rx_state;
      bit_tick     = 1'b0;
      byte_set     = 1'b0;
      ferr_set     = 1'b0;
      case (rx_state)
         RX_IDLE: if (rx_fall) rx_state_nxt = RX_START;
         RX_START: begin
            if (clk_cnt == HALF_LAST) rx_state_nxt = rx_sync_p1 ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (clk_cnt == BIT_LAST) begin
               bit_tick = 1'b1;
               if (bit_cnt == DATA_LAST) rx_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (clk_cnt == BIT_LAST) begin
               if (rx_sync_p1) begin
                  byte_set     = 1'b1;
                  rx_state_nxt = RX_IDLE;
               end else begin
                  ferr_set     = 1'b1;
                  rx_state_nxt = RX_RECOVER;
               end
            end
         end
         RX_RECOVER: if (rx_sync_p1) rx_state_nxt = RX_IDLE;
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_state     <= RX_IDLE;
         clk_cnt      <= '0;
         bit_cnt      <= '0;
         byte_stb     <= 1'b0;
         o_frameError <= 1'b0;
      end else begin
         rx_state     <= rx_state_nxt;
         byte_stb     <= byte_set;
         o_frameError <= ferr_set;
         if (rx_state == RX_IDLE || rx_state == RX_RECOVER ||
             rx_state_nxt != rx_state || bit_tick)
            clk_cnt <= '0;
         else
            clk_cnt <= clk_cnt + CNT_W'(1);
         if (rx_state == RX_IDLE)
            bit_cnt <= '0;
         else if (bit_tick)
            bit_cnt <= bit_cnt + BIT_W'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (bit_tick) rx_shift <= {rx_sync_p1, rx_shift[UART_DATA_SIZE-1:1]};
   end

   // Frame parser; a received byte outranks both frame error and timeout
   always_comb begin
      fr_state_nxt = fr_state;
      cmd_vld_set  = 1'b0;
      chk_err_set  = 1'b0;
      tmo_set      = 1'b0;
      if (byte_stb) begin
         case (fr_state)
            WAIT_HEADER: if (rx_shift == HEADER_BYTE) fr_state_nxt = GET_CMD;
            GET_CMD:     fr_state_nxt = GET_LO;
            GET_LO:      fr_state_nxt = GET_HI;
            GET_HI:      fr_state_nxt = GET_CHK;
            GET_CHK: begin
               fr_state_nxt = WAIT_HEADER;
               if (rx_shift == frame_chk(cmd_b, lo_b, hi_b)) cmd_vld_set = 1'b1;
               else                                          chk_err_set = 1'b1;
            end
            default: fr_state_nxt = WAIT_HEADER;
         endcase
      end else if (fr_state != WAIT_HEADER) begin
         if (o_frameError) begin
            fr_state_nxt = WAIT_HEADER;
         end else if (tmr >= TMR_LAST && !ferr_set) begin
            tmo_set      = 1'b1;
            fr_state_nxt = WAIT_HEADER;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fr_state        <= WAIT_HEADER;
         tmr             <= '0;
         o_cmdValid      <= 1'b0;
         o_checksumError <= 1'b0;
         o_timeout       <= 1'b0;
         o_cmd           <= '0;
         o_payload       <= '0;
      end else begin
         fr_state        <= fr_state_nxt;
         o_cmdValid      <= cmd_vld_set;
         o_checksumError <= chk_err_set;
         o_timeout       <= tmo_set;
         if (fr_state == WAIT_HEADER || byte_stb) tmr <= '0;
         else                                     tmr <= tmr + TMR_W'(1);
         if (cmd_vld_set) begin
            o_cmd     <= cmd_b;
            o_payload <= {hi_b, lo_b};
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (byte_stb) begin
         case (fr_state)
            GET_CMD: cmd_b <= rx_shift;
            GET_LO:  lo_b  <= rx_shift;
            GET_HI:  hi_b  <= rx_shift;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Randomized and directed bench for uart_cmd_receiver against a queue-based frame model.
module tb_uart_cmd_receiver;

   localparam int          CPB = 10;
   localparam int          TMO = 500;
   localparam logic [7:0]  HDR = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic [7:0]  o_cmd;
   logic [15:0] o_payload;
   logic        o_cmdValid, o_checksumError, o_frameError, o_timeout;

   always #5 clk = ~clk;

   uart_cmd_receiver #(
      .UART_CLK_FREQ (1_000_000),
      .UART_BAUDRATE (100_000),
      .UART_DATA_SIZE(8),
      .PAYLOAD_SIZE  (16),
      .HEADER_BYTE   (8'hA5),
      .TIMEOUT_TICKS (TMO)
   ) dut (
      .i_clock        (clk),
      .i_rst_n        (rst_n),
      .i_rxBit        (rx),
      .o_cmd          (o_cmd),
      .o_payload      (o_payload),
      .o_cmdValid     (o_cmdValid),
      .o_checksumError(o_checksumError),
      .o_frameError   (o_frameError),
      .o_timeout      (o_timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor
   int cyc = 0;
   int m_valid = 0, m_chk = 0, m_ferr = 0, m_tmo = 0;
   int valid_cyc = 0, tmo_cyc = 0;
   int strobes;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         strobes = int'(o_cmdValid) + int'(o_checksumError) + int'(o_frameError) + int'(o_timeout);
         if (strobes != 0) check_val("strobe_excl", strobes, 1);
         if (o_cmdValid)      begin m_valid++; valid_cyc = cyc; end
         if (o_checksumError) m_chk++;
         if (o_frameError)    m_ferr++;
         if (o_timeout)       begin m_tmo++; tmo_cyc = cyc; end
      end
   end

   // Reference model: bytes collected in a queue, frame judged once five are present
   logic [7:0]  mq[$];
   int          e_valid = 0, e_chk = 0, e_ferr = 0, e_tmo = 0;
   logic [7:0]  e_cmd = 8'h00;
   logic [15:0] e_pay = 16'h0000;

   task automatic model_byte(input logic [7:0] b);
      if (mq.size() == 0 && b != HDR) return;
      mq.push_back(b);
      if (mq.size() == 5) begin
         if ((mq[1] ^ mq[2] ^ mq[3]) == mq[4]) begin
            e_valid++;
            e_cmd = mq[1];
            e_pay = {mq[3], mq[2]};
         end else begin
            e_chk++;
         end
         mq.delete();
      end
   endtask

   // Stimulus: every task starts and ends 1 time unit after a rising edge
   int chr_start = 0;

   task automatic bit_time(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit_time(1'b1, n);
   endtask

   task automatic send_char(input logic [7:0] b, input bit bad_stop);
      chr_start = cyc;
      bit_time(1'b0, CPB);
      for (int i = 0; i < 8; i++) bit_time(b[i], CPB);
      if (bad_stop) bit_time(1'b0, 3 * CPB);
      bit_time(1'b1, CPB);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_char(b, 1'b0);
      model_byte(b);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [15:0] data, input logic [7:0] chk);
      send_good(HDR);
      send_good(cmd);
      send_good(data[7:0]);
      send_good(data[15:8]);
      send_good(chk);
   endtask

   task automatic check_state(input string tag);
      check_val({tag, "_nvalid"}, m_valid, e_valid);
      check_val({tag, "_nchkerr"}, m_chk, e_chk);
      check_val({tag, "_nferr"}, m_ferr, e_ferr);
      check_val({tag, "_ntmo"}, m_tmo, e_tmo);
      check_val({tag, "_cmd"}, o_cmd, e_cmd);
      check_val({tag, "_payload"}, o_payload, e_pay);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  c, g, k;
      logic [15:0] d;
      int          kind, stop_end, lat;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_cmd", o_cmd, 0);
      check_val("rst_payload", o_payload, 0);
      check_val("rst_valid", o_cmdValid, 0);
      check_val("rst_chkerr", o_checksumError, 0);
      check_val("rst_ferr", o_frameError, 0);
      check_val("rst_tmo", o_timeout, 0);
      rst_n = 1'b1;
      idle(20);

      send_frame(8'h01, 16'h1234, 8'h27);
      lat = valid_cyc - chr_start;
      idle(20);
      check_state("valid");
      check_val("valid_cmd_const", o_cmd, 8'h01);
      check_val("valid_payload_const", o_payload, 16'h1234);
      check_val("valid_latency", (lat >= 98 && lat <= 100), 1);

      send_frame(8'h01, 16'h1234, 8'h00);
      idle(20);
      check_state("badchk");
      send_frame(8'h07, 16'hBEEF, 8'h07 ^ 8'hEF ^ 8'hBE);
      idle(20);
      check_state("after_badchk");

      send_good(8'h00);
      send_good(8'hFF);
      send_frame(8'h02, 16'hABCD, 8'h64);
      idle(20);
      check_state("garbage");
      check_val("garbage_cmd_const", o_cmd, 8'h02);
      check_val("garbage_payload_const", o_payload, 16'hABCD);

      send_good(HDR);
      send_good(8'h01);
      stop_end = cyc;
      idle(600);
      mq.delete();
      e_tmo++;
      check_state("timeout");
      check_val("timeout_delay", (tmo_cyc - stop_end >= 480 && tmo_cyc - stop_end <= 520), 1);
      send_frame(8'h09, 16'h0F0F, 8'h09);
      idle(20);
      check_state("after_timeout");

      send_good(HDR);
      send_good(8'h01);
      send_char(8'h34, 1'b1);
      mq.delete();
      e_ferr++;
      send_good(8'h12);
      send_good(8'h27);
      idle(20);
      check_state("frameerr");
      send_frame(8'h11, 16'h2233, 8'h11 ^ 8'h22 ^ 8'h33);
      idle(20);
      check_state("after_frameerr");

      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(50);
      check_state("glitch");

      send_good(HDR);
      send_good(8'h03);
      bit_time(1'b0, CPB);
      bit_time(1'b1, CPB);
      bit_time(1'b0, CPB);
      #3 rst_n = 1'b0;
      #1;
      check_val("async_rst_cmd", o_cmd, 0);
      check_val("async_rst_payload", o_payload, 0);
      rx = 1'b1;
      mq.delete();
      e_cmd = 8'h00;
      e_pay = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(20);
      check_state("post_rst");
      send_frame(8'h05, 16'h5AA5, 8'h05 ^ 8'h5A ^ 8'hA5);
      idle(20);
      check_state("post_rst_frame");

      for (int it = 0; it < 16; it++) begin
         kind = int'($urandom_range(0, 3));
         c = 8'($urandom_range(0, 255));
         d = 16'($urandom_range(0, 65535));
         k = c ^ d[7:0] ^ d[15:8];
         case (kind)
            0: send_frame(c, d, k);
            1: send_frame(c, d, k ^ 8'($urandom_range(1, 255)));
            2: begin
               for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                  g = 8'($urandom_range(0, 255));
                  if (g == HDR) g = 8'h5A;
                  send_good(g);
               end
               send_frame(c, d, k);
            end
            default: begin
               send_good(HDR);   idle(int'($urandom_range(0, 300)));
               send_good(c);     idle(int'($urandom_range(0, 300)));
               send_good(d[7:0]); idle(int'($urandom_range(0, 300)));
               send_good(d[15:8]); idle(int'($urandom_range(0, 300)));
               send_good(k);
            end
         endcase
         idle(30);
         check_state($sformatf("rand%0d", it));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
